// File: rtl/loader_pkg.sv
// Shared definitions for the UART program loader.
// Contents:
//   loader_state_t - frame parser states
//   LOADER_HEADER  - byte that opens a frame
//   LOADER_HI_MASK - bits of a hi byte that must be zero
package loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StGetCount,
        StGetHi,
        StGetLo,
        StGetSum,
        StDone,
        StError
    } loader_state_t;

    localparam logic [7:0] LOADER_HEADER  = 8'hA5;
    localparam logic [7:0] LOADER_HI_MASK = 8'hF0;

endpackage

// File: rtl/uart_program_loader.sv
// UART program loader: parses framed bytes from the UART receiver into 12-bit program
// words, writes them to main memory and keeps the core in reset until a complete image
// with a matching checksum has been loaded.
// Frame: A5, N, N x {hi, lo}, checksum (8-bit sum of N and all hi/lo bytes).
// Ports:
//   clk, reset    - system clock, synchronous active-high reset
//   i_rx_valid    - one-cycle strobe, i_rx_byte holds a received byte
//   i_rx_byte     - received byte
//   o_mem_addr    - memory write address (BASE_ADDR + word index, 12-bit wrap)
//   o_mem_we      - one-cycle memory write strobe
//   o_mem_data    - word to write
//   o_core_hold   - 1 while the core must stay in reset
//   o_done        - image loaded and verified
//   o_error       - last load failed
//   o_word_count  - words written in the current/last load
module uart_program_loader
    import loader_pkg::*;
#(
    parameter int unsigned BASE_ADDR      = 0,
    parameter int unsigned MAX_WORDS      = 255,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_byte,
    output logic [11:0] o_mem_addr,
    output logic        o_mem_we,
    output logic [11:0] o_mem_data,
    output logic        o_core_hold,
    output logic        o_done,
    output logic        o_error,
    output logic [7:0]  o_word_count
);

    localparam int unsigned       TimerW    = $clog2(TIMEOUT_CYCLES + 1);
    // Value held by the timer on the last cycle a byte may still arrive.
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);
    localparam logic [11:0]       BaseAddr  = 12'(BASE_ADDR);

    loader_state_t     state_q, state_d;
    logic [7:0]        count_q, count_d;
    logic [3:0]        hi_q, hi_d;
    logic [7:0]        checksum_q, checksum_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [7:0]        word_count_q, word_count_d;
    logic [11:0]       mem_addr_q, mem_addr_d;
    logic [11:0]       mem_data_q, mem_data_d;
    logic              mem_we_q, mem_we_d;

    logic              in_frame;
    logic              is_header;
    logic [7:0]        sum_next;

    assign in_frame  = (state_q == StGetCount) || (state_q == StGetHi) ||
                       (state_q == StGetLo) || (state_q == StGetSum);
    assign is_header = (i_rx_byte == LOADER_HEADER);
    assign sum_next  = checksum_q + i_rx_byte;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        hi_d         = hi_q;
        checksum_d   = checksum_q;
        timer_d      = '0;
        word_count_d = word_count_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        mem_we_d     = 1'b0;

        unique case (state_q)
            StIdle, StDone, StError: begin
                if (i_rx_valid && is_header) begin
                    state_d      = StGetCount;
                    checksum_d   = '0;
                    word_count_d = '0;
                end
            end
            StGetCount: begin
                if (i_rx_valid) begin
                    if ((i_rx_byte == 8'd0) || (32'(i_rx_byte) > MAX_WORDS)) begin
                        state_d = StError;
                    end else begin
                        count_d    = i_rx_byte;
                        checksum_d = sum_next;
                        state_d    = StGetHi;
                    end
                end
            end
            StGetHi: begin
                if (i_rx_valid) begin
                    if ((i_rx_byte & LOADER_HI_MASK) != 8'd0) begin
                        state_d = StError;
                    end else begin
                        hi_d       = i_rx_byte[3:0];
                        checksum_d = sum_next;
                        state_d    = StGetLo;
                    end
                end
            end
            StGetLo: begin
                if (i_rx_valid) begin
                    checksum_d   = sum_next;
                    mem_we_d     = 1'b1;
                    mem_addr_d   = BaseAddr + {4'b0000, word_count_q};
                    mem_data_d   = {hi_q, i_rx_byte};
                    word_count_d = word_count_q + 8'd1;
                    state_d      = ((word_count_q + 8'd1) == count_q) ? StGetSum : StGetHi;
                end
            end
            StGetSum: begin
                if (i_rx_valid) begin
                    state_d = (i_rx_byte == checksum_q) ? StDone : StError;
                end
            end
            default: state_d = StIdle;
        endcase

        // Inter-byte timeout; a byte arriving on the expiry cycle takes precedence.
        if (in_frame && !i_rx_valid) begin
            if (timer_q == TimerLast) begin
                state_d = StError;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            count_q      <= '0;
            hi_q         <= '0;
            checksum_q   <= '0;
            timer_q      <= '0;
            word_count_q <= '0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_we_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            hi_q         <= hi_d;
            checksum_q   <= checksum_d;
            timer_q      <= timer_d;
            word_count_q <= word_count_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_we_q     <= mem_we_d;
        end
    end

    assign o_mem_addr   = mem_addr_q;
    assign o_mem_we     = mem_we_q;
    assign o_mem_data   = mem_data_q;
    assign o_word_count = word_count_q;
    // Only a verified image releases the core.
    assign o_done       = (state_q == StDone);
    assign o_core_hold  = (state_q != StDone);
    assign o_error      = (state_q == StError);

endmodule
